multicycle_control_unit: RTL and testbench

Sequenced control unit for the multicycle RV32I datapath. It replaces per-instruction combinational decode with a Moore FSM that drives one datapath step per cycle through fetch, decode, execute, memory and writeback. It waits on a memory ready handshake, with a bounded wait-state timeout. It sits between the instruction register and the shared-memory/ALU datapath, and adds I-type ALU ops, BNE, JAL, illegal-opcode trapping and a retire strobe.

---
 rtl/multicycle_control_unit.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: a Moore FSM that drives one datapath step per
// cycle through fetch, decode, execute, memory and writeback. Memory states wait
// on mem_ready under a bounded wait-state timeout. Unknown opcodes and timeouts
// park the FSM in a sticky FAULT state until reset.
module multicycle_control_unit #(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned WAIT_W     = 4,
  parameter int unsigned MAX_WAIT   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic                  adr_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  instr_done,
  output logic                  fault,
  output logic                  illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);

  localparam logic [WAIT_W-1:0] LP_MAX_WAIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_FAULT
  } state_t;

  state_t                  r_state;
  logic [WAIT_W-1:0]       r_wait;
  logic                    r_fault;
  logic                    r_illegal;
  logic [ALU_CTRL_W-1:0]   w_alu_r;
  logic [ALU_CTRL_W-1:0]   w_alu_i;

  // Funct3 ALU map shared by R and I forms; only the R form honours funct7 SUB.
  always_comb begin
    w_alu_i = ALU_ADD;
    case (funct3)
      3'b111:  w_alu_i = ALU_AND;
      3'b110:  w_alu_i = ALU_OR;
      default: w_alu_i = ALU_ADD;
    endcase
    w_alu_r = w_alu_i;
    if (funct3 == 3'b000 && funct7 == 7'b0100000) w_alu_r = ALU_SUB;
  end

  // State sequencing, wait-state counter and sticky fault flags.
  // The counter returns to zero whenever a wait state is left or not occupied,
  // which gives the clear-on-entry behaviour for FETCH, MEMRD and MEMWR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_fault   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_wait <= '0;
      case (r_state)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem_ready) begin
            case (r_state)
              S_FETCH: r_state <= S_DECODE;
              S_MEMRD: r_state <= S_MEMWB;
              default: r_state <= S_FETCH;
            endcase
          end else if (r_wait == LP_MAX_WAIT) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_R:              r_state <= S_EXEC_R;
            OP_IALU:           r_state <= S_EXEC_I;
            OP_JAL:            r_state <= S_JAL;
            OP_BRANCH: begin
              if (funct3 == 3'b000 || funct3 == 3'b001) begin
                r_state <= S_BRANCH;
              end else begin
                r_state   <= S_FAULT;
                r_fault   <= 1'b1;
                r_illegal <= 1'b1;
              end
            end
            default: begin
              r_state   <= S_FAULT;
              r_fault   <= 1'b1;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR: r_state <= (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
        S_MEMWB:  r_state <= S_FETCH;
        S_EXEC_R: r_state <= S_ALUWB;
        S_EXEC_I: r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_JAL:    r_state <= S_ALUWB;
        default:  r_state <= S_FAULT;
      endcase
    end
  end

  // Moore output decode from the state register; the only mem_ready terms are
  // the FETCH IR/PC load and the MEMWR completion strobe. Reset forces all zeros.
  always_comb begin
    alu_control = ALU_ADD;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    instr_done  = 1'b0;
    fault       = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      fault   = r_fault;
      illegal = r_illegal;
      case (r_state)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          adr_src  = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          adr_src    = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a   = 2'b10;
          alu_control = w_alu_r;
        end
        S_EXEC_I: begin
          alu_src_b   = 2'b01;
          alu_control = w_alu_i;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = 2'b10;
          alu_control = ALU_SUB;
          instr_done  = 1'b1;
          pc_write    = funct3[0] ? !zero : zero;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-instruction expected
// cycle traces are built from the instruction-level rules and compared against
// the full output vector every cycle.
module tb_multicycle_control_unit;

  localparam int unsigned MAX_WAIT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_control;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       adr_src, mem_read, mem_write, reg_write, ir_write, pc_write;
  logic       instr_done, fault, illegal;

  multicycle_control_unit #(
    .ALU_CTRL_W(3),
    .WAIT_W    (4),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_control(alu_control),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .adr_src    (adr_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .instr_done (instr_done),
    .fault      (fault),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  wire [17:0] obs = {alu_control, alu_src_a, alu_src_b, result_src, adr_src, mem_read,
                     mem_write, reg_write, ir_write, pc_write, instr_done, fault, illegal};

  int checks = 0;
  int passed = 0;

  // Instruction classes used by the reference model.
  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BEQ = 4, K_BNE = 5, K_JAL = 6;

  logic [17:0] exp_q[$];
  bit          rdy_q[$];

  function automatic logic [17:0] mk(int alu, int a, int b, int rs, bit adr, bit mr, bit mw,
                                     bit rw, bit irw, bit pcw, bit done, bit flt, bit ill);
    return {3'(alu), 2'(a), 2'(b), 2'(rs), adr, mr, mw, rw, irw, pcw, done, flt, ill};
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic push(input bit r, input logic [17:0] v);
    rdy_q.push_back(r);
    exp_q.push_back(v);
  endtask

  // Each entry is one cycle: drive mem_ready, compare mid-cycle, advance.
  task automatic play(input string tag);
    logic [17:0] v;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      v = exp_q.pop_front();
      @(negedge clk);
      check(tag, obs, v);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("reset_zero", obs, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Fetch step: fw wait cycles, then the completing cycle loads IR and PC.
  task automatic model_fetch(input int fw);
    repeat (fw) push(1'b0, mk(0, 0, 2, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    push(1'b1, mk(0, 0, 2, 2, 0, 1, 0, 0, 1, 1, 0, 0, 0));
  endtask

  task automatic model_decode();
    push(1'($urandom), mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  function automatic int alu_of(input int kind, input logic [2:0] f3, input logic [6:0] f7);
    if (f3 == 3'd7) return 2;
    if (f3 == 3'd6) return 3;
    if (kind == K_R && f3 == 3'd0 && f7 == 7'h20) return 1;
    return 0;
  endfunction

  // Build the complete expected trace of one legal instruction and run it.
  task automatic run_instr(input int kind, input int fw, input int mw, input string tag);
    int a;
    case (kind)
      K_R:     opcode = 7'b0110011;
      K_I:     opcode = 7'b0010011;
      K_LOAD:  opcode = 7'b0000011;
      K_STORE: opcode = 7'b0100011;
      K_JAL:   opcode = 7'b1101111;
      default: opcode = 7'b1100011;
    endcase
    if (kind == K_BEQ) funct3 = 3'd0;
    else if (kind == K_BNE) funct3 = 3'd1;
    model_fetch(fw);
    model_decode();
    case (kind)
      K_R, K_I: begin
        a = alu_of(kind, funct3, funct7);
        if (kind == K_R) push(1'($urandom), mk(a, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        else             push(1'($urandom), mk(a, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      end
      K_LOAD: begin
        push(1'($urandom), mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (mw) push(1'b0, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        push(1'b1, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        push(1'($urandom), mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      end
      K_STORE: begin
        push(1'($urandom), mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (mw) push(1'b0, mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        push(1'b1, mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
      end
      K_BEQ, K_BNE: begin
        push(1'($urandom), mk(1, 2, 0, 0, 0, 0, 0, 0, 0,
                              (kind == K_BEQ) ? zero : !zero, 1, 0, 0));
      end
      default: begin
        push(1'($urandom), mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        push(1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      end
    endcase
    play(tag);
  endtask

  // Illegal decode: one DECODE cycle, then a quiet FAULT with both flags set.
  task automatic run_illegal(input int cycles, input string tag);
    model_fetch(0);
    model_decode();
    repeat (cycles) push(1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    play(tag);
    do_reset();
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0000011 || op == 7'b0010011 ||
           op == 7'b0100011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  initial begin
    logic [6:0] op;
    int         kind;

    do_reset();

    // add x3,x1,x2 then sub, zero-wait memory
    funct3 = 3'd0; funct7 = 7'h00;
    run_instr(K_R, 0, 0, "add");
    funct7 = 7'h20;
    run_instr(K_R, 0, 0, "sub");
    // I-form ignores funct7: no SUBI
    run_instr(K_I, 0, 0, "addi_f7");
    funct3 = 3'd7; run_instr(K_I, 0, 0, "andi");
    funct3 = 3'd6; run_instr(K_R, 0, 0, "or");

    // lw with three MEMRD wait cycles
    run_instr(K_LOAD, 0, 3, "lw_wait3");

    // branches
    zero = 1'b1; run_instr(K_BEQ, 0, 0, "beq_taken");
    zero = 1'b0; run_instr(K_BEQ, 0, 0, "beq_not");
    zero = 1'b0; run_instr(K_BNE, 0, 0, "bne_taken");
    zero = 1'b1; run_instr(K_BNE, 0, 0, "bne_not");
    run_instr(K_JAL, 0, 0, "jal");

    // ready arriving exactly on the limit cycle is a normal transition
    funct3 = 3'd0; funct7 = 7'h00;
    run_instr(K_R, MAX_WAIT, 0, "fetch_limit_ok");
    run_instr(K_STORE, 0, MAX_WAIT, "memwr_limit_ok");
    run_instr(K_LOAD, 0, MAX_WAIT, "memrd_limit_ok");

    // illegal opcode 0x7F and an unsupported branch funct3
    opcode = 7'h7F;
    run_illegal(20, "illegal_7f");
    opcode = 7'b1100011; funct3 = 3'd4;
    run_illegal(5, "illegal_br_f3");
    funct3 = 3'd0;
    run_instr(K_R, 0, 0, "after_illegal");

    // fetch timeout: MAX_WAIT+1 FETCH cycles then FAULT with illegal=0
    repeat (MAX_WAIT + 1) push(1'b0, mk(0, 0, 2, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    repeat (4) push(1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    play("fetch_timeout");
    do_reset();

    // memory-read timeout
    opcode = 7'b0000011;
    model_fetch(0);
    model_decode();
    push(1'b0, mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (MAX_WAIT + 1) push(1'b0, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) push(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    play("memrd_timeout");
    do_reset();

    // reset pulsed mid-MEMWR with ready low: strobes drop at once, restart in FETCH
    opcode = 7'b0100011;
    model_fetch(0);
    model_decode();
    push(1'b0, mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1'b0, mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    play("memwr_pre");
    mem_ready = 1'b0;
    #2;
    check("memwr_hold", obs, mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    check("rst_async", obs, '0);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_held", obs, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    funct3 = 3'd7; funct7 = 7'h00;
    run_instr(K_R, 0, 0, "restart_and");

    // randomized legal instruction stream with random wait states
    for (int n = 0; n < 40; n++) begin
      kind   = $urandom_range(0, 6);
      funct3 = 3'($urandom);
      funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
      zero   = 1'($urandom);
      run_instr(kind, $urandom_range(0, 3), $urandom_range(0, 3), "rand_instr");
    end

    // randomized illegal opcode
    op = 7'($urandom);
    while (legal_op(op)) op = 7'($urandom);
    opcode = op;
    run_illegal(3, "rand_illegal");
    run_instr(K_JAL, 1, 0, "final_jal");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
